// File: rtl/gcd_ctrl_fsm_if.sv
// Handshake and datapath-control bundle for gcd_ctrl_fsm.
// slave  : the controller (receives start/ack and datapath flags, drives controls)
// master : the requester plus the datapath (drives start/ack and flags)
interface gcd_ctrl_fsm_if;
  logic start;
  logic ack;
  logic x_eq_y;
  logic x_lt_y;
  logic x_zero;
  logic y_zero;
  logic enable;
  logic ld_x;
  logic ld_y;
  logic sel_x;
  logic sel_y;
  logic GCD_in;
  logic busy;
  logic done;
  logic err;

  modport master (
    output start, ack, x_eq_y, x_lt_y, x_zero, y_zero,
    input  enable, ld_x, ld_y, sel_x, sel_y, GCD_in, busy, done, err
  );

  modport slave (
    input  start, ack, x_eq_y, x_lt_y, x_zero, y_zero,
    output enable, ld_x, ld_y, sel_x, sel_y, GCD_in, busy, done, err
  );
endinterface

// File: rtl/gcd_ctrl_fsm.sv
// Controller for the 4-bit subtractive GCD datapath.
// Moore FSM: load, compare, subtract, write-back, then hold done/err until ack.
// Optional macro GCD_CTRL_TIMEOUT_EN builds an iteration counter that ends a
// run in ERR once MAX_ITER subtractions have been made without convergence.
module gcd_ctrl_fsm #(
  parameter int MAX_ITER = 15,
  parameter int CNT_W    = 5
) (
  input logic         clk,
  input logic         reset,
  gcd_ctrl_fsm_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_SUB_X = 3'd3;
  localparam logic [2:0] S_SUB_Y = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  // The counter must be able to hold MAX_ITER without wrapping.
  if ((64'd1 << CNT_W) <= 64'(MAX_ITER)) begin : g_cnt_w_check
    $error("gcd_ctrl_fsm: CNT_W too narrow for MAX_ITER");
  end

  logic [2:0] state_q, state_d;
  logic       timeout;

`ifdef GCD_CTRL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] ITER_LIM = CNT_W'(MAX_ITER);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Iteration counter: cleared on load, saturating increment per subtract step.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_LOAD) begin
      cnt_d = '0;
    end else if ((state_q == S_SUB_X || state_q == S_SUB_Y) && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign timeout = (cnt_q == ITER_LIM);
`else
  assign timeout = 1'b0;
`endif

  // Next-state logic; CHECK priority: zero operand, equal, timeout, less-than.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_LOAD;
      S_LOAD:  state_d = S_CHECK;
      S_CHECK: begin
        if (bus.x_zero || bus.y_zero) state_d = S_ERR;
        else if (bus.x_eq_y)          state_d = S_WRITE;
        else if (timeout)             state_d = S_ERR;
        else if (bus.x_lt_y)          state_d = S_SUB_Y;
        else                          state_d = S_SUB_X;
      end
      S_SUB_X: state_d = S_CHECK;
      S_SUB_Y: state_d = S_CHECK;
      S_WRITE: state_d = S_DONE;
      S_DONE:  if (bus.ack) state_d = S_IDLE;
      S_ERR:   if (bus.ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Moore output decode from the state register.
  always_comb begin
    bus.enable = 1'b0;
    bus.ld_x   = 1'b0;
    bus.ld_y   = 1'b0;
    bus.sel_x  = 1'b0;
    bus.sel_y  = 1'b0;
    bus.GCD_in = 1'b0;
    bus.busy   = (state_q != S_IDLE);
    bus.done   = 1'b0;
    bus.err    = 1'b0;
    case (state_q)
      S_LOAD: begin
        bus.enable = 1'b1;
        bus.ld_x   = 1'b1;
        bus.ld_y   = 1'b1;
      end
      S_SUB_X: begin
        bus.enable = 1'b1;
        bus.ld_x   = 1'b1;
        bus.sel_x  = 1'b1;
      end
      S_SUB_Y: begin
        bus.enable = 1'b1;
        bus.ld_y   = 1'b1;
        bus.sel_y  = 1'b1;
      end
      S_WRITE: bus.GCD_in = 1'b1;
      S_DONE:  bus.done   = 1'b1;
      S_ERR: begin
        bus.done = 1'b1;
        bus.err  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gcd_ctrl_fsm.sv
// Bench for gcd_ctrl_fsm: behavioural 4-bit datapath plus a cycle-schedule
// model derived from plain Euclid subtraction on the operands.
module tb_gcd_ctrl_fsm;

`ifdef GCD_CTRL_TIMEOUT_EN
  localparam int TO_EN = 1;
  localparam int MAXI  = 3;
`else
  localparam int TO_EN = 0;
  localparam int MAXI  = 15;
`endif
  localparam int MAXC = 64;

  // Output vector order: enable ld_x ld_y sel_x sel_y GCD_in busy done err
  localparam logic [8:0] V_LOAD  = 9'b111_00_0_1_00;
  localparam logic [8:0] V_SUBX  = 9'b110_10_0_1_00;
  localparam logic [8:0] V_SUBY  = 9'b101_01_0_1_00;
  localparam logic [8:0] V_CHECK = 9'b000_00_0_1_00;
  localparam logic [8:0] V_WRITE = 9'b000_00_1_1_00;
  localparam logic [8:0] V_DONE  = 9'b000_00_0_1_10;
  localparam logic [8:0] V_ERR   = 9'b000_00_0_1_11;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gcd_ctrl_fsm_if bus();

  gcd_ctrl_fsm #(.MAX_ITER(MAXI), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural datapath
  logic [3:0] x_in = '0, y_in = '0;
  logic [3:0] x_r = '0, y_r = '0, gcd_out = '0;
  int gcd_pulses = 0;

  assign bus.x_eq_y = (x_r == y_r);
  assign bus.x_lt_y = (x_r <  y_r);
  assign bus.x_zero = (x_r == 4'd0);
  assign bus.y_zero = (y_r == 4'd0);

  always @(posedge clk) begin
    if (bus.enable && bus.ld_x) x_r <= bus.sel_x ? (x_r - y_r) : x_in;
    if (bus.enable && bus.ld_y) y_r <= bus.sel_y ? (y_r - x_r) : y_in;
    if (bus.GCD_in) begin
      gcd_out <= x_r;
      gcd_pulses <= gcd_pulses + 1;
    end
  end

  logic [8:0] out_vec;
  assign out_vec = {bus.enable, bus.ld_x, bus.ld_y, bus.sel_x, bus.sel_y,
                    bus.GCD_in, bus.busy, bus.done, bus.err};

  int tests = 0;
  int fails = 0;

  // Expected trace, indexed by cycle number (LOAD = cycle 1)
  logic [8:0] exp_v [MAXC];
  int  cyc = 0;
  int  first_done = 0;
  bit  mon = 1'b0;

  // Single compare process: every monitored cycle against the model trace.
  always @(negedge clk) begin
    if (mon) begin
      cyc++;
      if (cyc < MAXC) begin
        tests++;
        if (out_vec !== exp_v[cyc]) begin
          fails++;
          $display("FAIL trace cycle %0d: got %b expected %b", cyc, out_vec, exp_v[cyc]);
        end
      end
      if (bus.done === 1'b1 && first_done == 0) first_done = cyc;
    end
  end

  task automatic check(input string name, input int got, input int expv);
    tests++;
    if (got != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  // Euclid by repeated subtraction -> cycle schedule of control outputs.
  task automatic build_model(input logic [3:0] x, input logic [3:0] y, input int hold,
                             output int dcyc, output logic eerr, output logic [3:0] g);
    logic [3:0] a, b;
    int k;
    for (int i = 0; i < MAXC; i++) exp_v[i] = '0;
    exp_v[1] = V_LOAD;
    a = x; b = y; k = 0; g = '0;
    if (x == 4'd0 || y == 4'd0) begin
      exp_v[2] = V_CHECK;
      dcyc = 3;
      eerr = 1'b1;
    end else begin
      while (a != b && !(TO_EN == 1 && k == MAXI)) begin
        exp_v[2 + 2*k] = V_CHECK;
        if (a < b) begin exp_v[3 + 2*k] = V_SUBY; b = b - a; end
        else       begin exp_v[3 + 2*k] = V_SUBX; a = a - b; end
        k++;
      end
      exp_v[2 + 2*k] = V_CHECK;
      if (a == b) begin
        exp_v[3 + 2*k] = V_WRITE;
        dcyc = 4 + 2*k;
        eerr = 1'b0;
        g = a;
      end else begin
        dcyc = 3 + 2*k;
        eerr = 1'b1;
      end
    end
    for (int c = dcyc; c <= dcyc + hold; c++) exp_v[c] = eerr ? V_ERR : V_DONE;
  endtask

  // One run: start, optional stray start / start-with-ack / mid-run reset.
  task automatic run(input string name, input logic [3:0] x, input logic [3:0] y,
                     input int hold, input int lit_done, input bit lit_err,
                     input logic [3:0] lit_g, input int start_at, input bit start_ack,
                     input int reset_at);
    int dc;
    logic ee;
    logic [3:0] g;
    int p0;
    build_model(x, y, hold, dc, ee, g);
    @(negedge clk); #2;
    x_in = x; y_in = y; bus.start = 1'b1;
    p0 = gcd_pulses;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 0; first_done = 0; mon = 1'b1;
    for (int c = 1; c <= dc + hold + 2; c++) begin
      @(negedge clk); #2;
      if (c == reset_at) begin
        mon = 1'b0;
        reset = 1'b1;
        #1;
        check({name, "_reset_outputs"}, int'(out_vec), 0);
        @(negedge clk); #2;
        reset = 1'b0;
        check({name, "_reset_no_gcd_in"}, gcd_pulses - p0, 0);
        return;
      end
      if (c == start_at) bus.start = 1'b1;
      else if (c == start_at + 1) bus.start = 1'b0;
      if (c == dc + hold) begin
        bus.ack = 1'b1;
        if (start_ack) bus.start = 1'b1;
      end
      if (c == dc + hold + 1) begin
        bus.ack = 1'b0;
        bus.start = 1'b0;
      end
    end
    mon = 1'b0;
    check({name, "_done_cycle"}, first_done, lit_done);
    check({name, "_gcd_in_pulses"}, gcd_pulses - p0, lit_err ? 0 : 1);
    if (!lit_err) check({name, "_gcd_out"}, int'(gcd_out), int'(lit_g));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", int'(out_vec), 0);
    #2 reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", int'(out_vec), 0);

    //   name       x      y      hold done err g     stray ack+st rst
    run("r12_8",   4'd12, 4'd8,  5,   8,   0,  4'd4, 0,    0,     0);
    run("r7_7",    4'd7,  4'd7,  0,   4,   0,  4'd7, 0,    0,     0);
    if (TO_EN == 1)
      run("r15_1_to", 4'd15, 4'd1, 1, 9,   1,  4'd0, 0,    0,     0);
    else
      run("r15_1",  4'd15, 4'd1, 1,   32,  0,  4'd1, 0,    0,     0);
    run("r0_9",    4'd0,  4'd9,  2,   3,   1,  4'd0, 0,    0,     0);
    run("r9_0",    4'd9,  4'd0,  0,   3,   1,  4'd0, 0,    0,     0);
    run("r4_1",    4'd4,  4'd1,  0,   10,  0,  4'd1, 0,    0,     0);
    run("stray",   4'd12, 4'd8,  0,   8,   0,  4'd4, 3,    0,     0);
    run("st_ack",  4'd9,  4'd6,  2,   8,   0,  4'd3, 0,    1,     0);
    run("abort",   4'd12, 4'd8,  0,   8,   0,  4'd4, 0,    0,     5);
    @(negedge clk);
    check("post_reset_idle", int'(out_vec), 0);
    run("rerun",   4'd12, 4'd8,  0,   8,   0,  4'd4, 0,    0,     0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/gcd_ctrl_fsm.md
# gcd_ctrl_fsm

Control unit for the 4-bit subtractive GCD datapath. It drives the datapath's `enable`, `sel_x`, `sel_y` and `GCD_in` controls and sequences load, compare, subtract and write-back from the datapath's status flags. Software and test logic talk to it through a start/done/ack handshake. It is the controller half of the GCD FSM + datapath pair and sits directly above the datapath in the lab top level.

## Interface
- `MAX_ITER`, default 15: maximum subtract steps before a timeout error. Only used when the timeout feature is compiled in.
- `CNT_W`, default 5: iteration counter width. Must satisfy 2^CNT_W > MAX_ITER.

- `clk`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-high; forces IDLE immediately
- `start`  in  1  request a GCD run; sampled in IDLE only
- `ack`  in  1  consumer acknowledges the result; sampled in DONE/ERR only
- `x_eq_y`  in  1  datapath flag: X register == Y register
- `x_lt_y`  in  1  datapath flag: X register < Y register
- `x_zero`  in  1  datapath flag: X register == 0
- `y_zero`  in  1  datapath flag: Y register == 0
- `enable`  out  1  datapath register load strobe
- `ld_x`  out  1  X register write enable (qualified by `enable`)
- `ld_y`  out  1  Y register write enable (qualified by `enable`)
- `sel_x`  out  1  X mux: 0 = `X_in`, 1 = X−Y
- `sel_y`  out  1  Y mux: 0 = `Y_in`, 1 = Y−X
- `GCD_in`  out  1  one-cycle strobe that loads X into the `GCD_out` register
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  result or error available; held until `ack`
- `err`  out  1  valid with `done`: 1 = zero operand or timeout

## Operation
Outputs are decoded from the state register (Moore). Any output not listed for a state is 0.

- **IDLE**: `start` = 1 → LOAD. Otherwise stay.
- **LOAD**: `enable`, `ld_x`, `ld_y` = 1 with `sel_x` = `sel_y` = 0. Clears the iteration counter. → CHECK.
- **CHECK**: evaluates the flags in this priority order, highest first:
  1. `x_zero` | `y_zero` → ERR
  2. `x_eq_y` → WRITE
  3. timeout (counter == `MAX_ITER`, macro builds only) → ERR
  4. `x_lt_y` → SUB_Y
  5. otherwise → SUB_X
- **SUB_X**: `enable`, `ld_x`, `sel_x` = 1 (X ← X−Y). Counter +1. → CHECK.
- **SUB_Y**: `enable`, `ld_y`, `sel_y` = 1 (Y ← Y−X). Counter +1. → CHECK.
- **WRITE**: `GCD_in` = 1 for exactly one cycle. → DONE.
- **DONE**: `done` = 1, `err` = 0. `ack` → IDLE.
- **ERR**: `done` = 1, `err` = 1, and `GCD_in` is never pulsed. `ack` → IDLE.

Boundary conditions:
- `start` while `busy` is ignored; it is not queued.
- `ack` outside DONE/ERR is ignored.
- `start` and `ack` high together in DONE/ERR: `ack` wins → IDLE, and `start` must be re-asserted in IDLE.
- Inconsistent flags (`x_eq_y` and `x_lt_y` both 1): `x_eq_y` wins.
- The counter saturates at 2^CNT_W−1. It never wraps.
- Illegal or unused state encodings → IDLE on the next edge.

## Timing
- Reset values: state IDLE, counter 0, every output 0. Reset asserted mid-run aborts at once with no `GCD_in` pulse.
- Cycle numbering: `start` is sampled at edge 0.
  - LOAD is cycle 1 and the first CHECK is cycle 2.
  - Each subtract step costs 2 cycles (SUB, then CHECK).
  - For k subtractions: WRITE is at cycle 3+2k and `done` first goes high at cycle 4+2k.
  - Errors: zero operand gives `done`/`err` at cycle 3. Timeout gives them at cycle 3+2·`MAX_ITER`.
- The datapath flags must be valid combinationally from the registered X/Y values in the cycle after any load.
- `done` falls on the edge after `ack` is sampled; the earliest next `start` is sampled one cycle later.

## Configuration
- **`GCD_CTRL_TIMEOUT_EN` defined**: the iteration counter and the CHECK timeout branch are built, and a run exceeding `MAX_ITER` subtractions ends in ERR.
- **`GCD_CTRL_TIMEOUT_EN` undefined**: no counter logic exists, and `err` is raised only for zero operands.

## Test plan
The bench pairs the controller with a behavioral 4-bit datapath model.
- X=12, Y=8 (k=2: SUB_X then SUB_Y) → `GCD_in` pulse at cycle 7, `done`=1 and `err`=0 at cycle 8, `GCD_out`=4; hold `ack` low for 5 cycles → `done` stays high; `ack` → IDLE.
- X=7, Y=7 → WRITE at cycle 3, `done` at cycle 4, `GCD_out`=7. Repeat with X=15, Y=1 (k=14) → `done` at cycle 32, `GCD_out`=1.
- X=0, Y=9 → `done`=1 and `err`=1 at cycle 3, `GCD_in` never asserted.
- Macro on, `MAX_ITER`=3, X=15, Y=1 → `err`=1 at cycle 9. Macro off, same stimulus → normal result 1 at cycle 32.
- `start` pulsed during SUB_X → ignored, result unchanged. `start`+`ack` together in DONE → returns to IDLE with no new LOAD.
- `reset` asserted at cycle 5 of the X=12, Y=8 run → all outputs 0 asynchronously, state IDLE. A subsequent `start` → a correct full run.
